// File: rtl/j1_io_pkg.sv
// Shared constants and types for the j1 UART I/O peripheral: register map,
// status bit positions and the TX/RX state machine encodings.
package j1_io_pkg;

  localparam logic [15:0] ADDR_DATA = 16'h1000;
  localparam logic [15:0] ADDR_STAT = 16'h2000;

  localparam int unsigned STAT_TX_FULL    = 0;
  localparam int unsigned STAT_TX_BUSY    = 1;
  localparam int unsigned STAT_RX_VALID   = 2;
  localparam int unsigned STAT_RX_OVERRUN = 3;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  function automatic logic [31:0] stat_word(input logic rx_overrun,
                                            input logic rx_valid,
                                            input logic tx_busy,
                                            input logic tx_full);
    logic [31:0] w;
    w                  = '0;
    w[STAT_TX_FULL]    = tx_full;
    w[STAT_TX_BUSY]    = tx_busy;
    w[STAT_RX_VALID]   = rx_valid;
    w[STAT_RX_OVERRUN] = rx_overrun;
    return w;
  endfunction

endpackage

// File: rtl/j1_io_uart_if.sv
// j1 core I/O bus: address, read/write strobes and the two data directions.
interface j1_io_uart_if;

  logic [15:0] io_addr;
  logic        io_rd;
  logic        io_wr;
  logic [31:0] io_dout;
  logic [31:0] io_din;

  modport master (
    output io_addr,
    output io_rd,
    output io_wr,
    output io_dout,
    input  io_din
  );

  modport slave (
    input  io_addr,
    input  io_rd,
    input  io_wr,
    input  io_dout,
    output io_din
  );

endinterface

// File: rtl/j1_sync_fifo.sv
// Single-clock FIFO with first-word fall-through head; DEPTH must be a power of 2
// so the pointers wrap naturally.
module j1_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned   AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // A pop frees a slot on the same edge, so a push against a full FIFO is taken when paired with one.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/j1_io_uart.sv
// Memory-mapped UART for the j1 core: DATA/STAT registers, TX FIFO feeding an
// 8N1 transmitter, and a synchronised 8N1 receiver with valid/overrun flags.
module j1_io_uart
  import j1_io_pkg::*;
#(
  parameter int unsigned CLKDIV  = 868,
  parameter int unsigned TXDEPTH = 16
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic [15:0] io_addr,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [31:0] io_dout,
  output logic [31:0] io_din,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam logic [15:0] DIV_LAST  = 16'(CLKDIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKDIV / 2 - 1);

  logic       sel_data, sel_stat, wr_data, rd_data;
  logic       fifo_full, fifo_empty, tx_pop, tx_busy;
  logic [7:0] fifo_head;
  logic       unused_dout;

  assign sel_data    = (io_addr == ADDR_DATA);
  assign sel_stat    = (io_addr == ADDR_STAT);
  assign wr_data     = io_wr && sel_data;
  assign rd_data     = io_rd && sel_data;
  assign unused_dout = ^io_dout[31:8];

  j1_sync_fifo #(.WIDTH(8), .DEPTH(TXDEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (resetq),
    .push  (wr_data),
    .pop   (tx_pop),
    .din   (io_dout[7:0]),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------- transmitter ----------------
  tx_state_e  tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_line_q, tx_line_d;

  assign tx_busy = (tx_state_q != TX_IDLE) || !fifo_empty;
  assign uart_tx = tx_line_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_line_d = 1'b1;
        if (!fifo_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = fifo_head;
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
          tx_line_d  = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == DIV_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
          tx_line_d  = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == DIV_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_line_d  = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == DIV_LAST) begin
          tx_cnt_d = '0;
          // Chain straight into the next start bit so queued bytes go out back-to-back.
          if (!fifo_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = fifo_head;
            tx_state_d = TX_START;
            tx_line_d  = 1'b0;
          end else begin
            tx_state_d = TX_IDLE;
            tx_line_d  = 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_line_d  = 1'b1;
      end
    endcase
  end

  // ---------------- receiver ----------------
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_done;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          rx_done    = rx_s2_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- register file ----------------
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_overrun_q, rx_overrun_d;
  logic [31:0] io_din_q, io_din_d;

  assign io_din = io_din_q;

  always_comb begin
    rx_byte_d    = rx_byte_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = rx_overrun_q;
    io_din_d     = io_din_q;
    if (io_rd) begin
      if (sel_data)      io_din_d = {24'b0, rx_byte_q};
      else if (sel_stat) io_din_d = stat_word(rx_overrun_q, rx_valid_q, tx_busy, fifo_full);
      else               io_din_d = '0;
    end
    if (rd_data) begin
      rx_valid_d   = 1'b0;
      rx_overrun_d = 1'b0;
    end
    // A read landing on completion consumes the old byte, so the new one is not an overrun.
    if (rx_done) begin
      rx_byte_d    = rx_shift_q;
      rx_valid_d   = 1'b1;
      rx_overrun_d = rd_data ? 1'b0 : (rx_overrun_q || rx_valid_q);
    end
  end

  always_ff @(posedge clk or posedge resetq) begin
    if (resetq) begin
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      tx_line_q    <= 1'b1;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_byte_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      io_din_q     <= '0;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_line_q    <= tx_line_d;
      rx_s1_q      <= uart_rx;
      rx_s2_q      <= rx_s1_q;
      rx_prev_q    <= rx_s2_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_byte_q    <= rx_byte_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      io_din_q     <= io_din_d;
    end
  end

endmodule
